// File: rtl/seq_ctrl.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with stall, retire counter and optional trap.
// Define SEQ_TRAP_EN to halt on illegal instructions; otherwise they retire as NOPs.
module seq_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  output logic [31:0] instruction,
  input  logic        dec_reg_we,
  input  logic        dec_mem_we,
  input  logic [1:0]  dec_reg_sel_data_in,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        pc_we,
  output logic        reg_we,
  output logic [2:0]  state,
  output logic [31:0] instret,
  output logic        trap
);

  // state  | meaning
  // FETCH  | request instruction word, latch on imem_ready
  // DECODE | one cycle for the decoder to settle; illegal check
  // EXEC   | one cycle; choose MEM for loads/stores, WB otherwise
  // MEM    | data access; stores retire here
  // WB     | register write-back and PC update
  // HALT   | illegal instruction trap, left only by reset
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  state_t state_q, state_d;
  logic   legal_opc, illegal, is_load, en;
  logic   fetch_c, mreq_c, mwe_c, pc_c, rwe_c;

  always_comb begin
    case (instruction[6:2])
      5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b11000,
      5'b11011, 5'b11001, 5'b01101, 5'b00101: legal_opc = 1'b1;
      default:                                legal_opc = 1'b0;
    endcase
  end

  assign illegal = (instruction[1:0] != 2'b11) || !legal_opc;
  assign is_load = dec_reg_we && (dec_reg_sel_data_in == 2'b01);

  always_comb begin
    state_d = state_q;
    fetch_c = 1'b0;
    mreq_c  = 1'b0;
    mwe_c   = 1'b0;
    pc_c    = 1'b0;
    rwe_c   = 1'b0;
    case (state_q)
      FETCH: begin
        fetch_c = 1'b1;
        if (imem_ready) state_d = DECODE;
      end
      DECODE: begin
`ifdef SEQ_TRAP_EN
        state_d = illegal ? HALT : EXEC;
`else
        state_d = EXEC;
`endif
      end
      EXEC: begin
        // Illegal words only get here as NOPs, so they never touch data memory.
        if (!illegal && (dec_mem_we || is_load)) state_d = MEM;
        else                                     state_d = WB;
      end
      MEM: begin
        mreq_c = 1'b1;
        mwe_c  = dec_mem_we;
        if (dmem_ready) begin
          if (dec_mem_we) begin
            pc_c    = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end
      end
      WB: begin
        pc_c    = 1'b1;
        rwe_c   = dec_reg_we && !illegal;
        state_d = FETCH;
      end
      HALT: begin
`ifdef SEQ_TRAP_EN
        state_d = HALT;
`else
        state_d = FETCH;
`endif
      end
      default: state_d = FETCH;
    endcase
  end

  // Stall and reset suppress every strobe combinationally.
  assign en       = !stall && !reset;
  assign imem_req = fetch_c && en;
  assign dmem_req = mreq_c && en;
  assign dmem_we  = mwe_c && en;
  assign pc_we    = pc_c && en;
  assign reg_we   = rwe_c && en;
  assign state    = state_q;

`ifdef SEQ_TRAP_EN
  assign trap = (state_q == HALT);
`else
  assign trap = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FETCH;
      instruction <= 32'h0000_0013;
      instret     <= 32'd0;
    end else begin
      // Undefined codes recover even while stalled.
      if (!stall || (state_q > HALT)) state_q <= state_d;
      if (imem_req && imem_ready) instruction <= imem_data;
      if (pc_we) instret <= instret + 32'd1;
    end
  end

endmodule

// File: tb/tb_seq_ctrl.sv
// Self-checking bench for seq_ctrl: directed scenarios plus randomized instruction stream
// checked against a per-instruction timing model derived from the sequencing rules.
module tb_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset, stall, imem_ready, dec_reg_we, dec_mem_we, dmem_ready;
  logic [31:0] imem_data;
  logic [1:0]  dec_sel;
  logic        imem_req, dmem_req, dmem_we, pc_we, reg_we, trap;
  logic [31:0] instruction, instret;
  logic [2:0]  state;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          inv_err  = 0;
  logic [31:0] exp_instret;

  seq_ctrl dut (
    .clk(clk), .reset(reset), .stall(stall),
    .imem_req(imem_req), .imem_ready(imem_ready), .imem_data(imem_data),
    .instruction(instruction),
    .dec_reg_we(dec_reg_we), .dec_mem_we(dec_mem_we), .dec_reg_sel_data_in(dec_sel),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .pc_we(pc_we), .reg_we(reg_we), .state(state), .instret(instret), .trap(trap)
  );

  always #5 clk = ~clk;

  // reg_we may only appear in WB; pc_we outside WB must come without reg_we.
  always @(posedge clk) begin
    if (!reset && reg_we && state != 3'd4) inv_err++;
  end

  // cls: 0 = non-memory, 1 = load, 2 = store, 3 = illegal (NOP when trapping is off)
  task automatic run_instr(input logic [31:0] word, input int cls, input int wi,
                           input int wd, input logic rwe);
    int   is_mem, exp_pc, exp_st, got_pc, st_err, n_ireq, n_dreq, n_dwe;
    logic got_rwe;
    is_mem = (cls == 1 || cls == 2) ? 1 : 0;
    exp_pc = wi + 3 + (is_mem ? wd + (cls == 1 ? 1 : 0) : 0);
    got_pc = -1; got_rwe = 1'b0; st_err = 0; n_ireq = 0; n_dreq = 0; n_dwe = 0;
    case (cls)
      0: begin dec_reg_we = rwe; dec_mem_we = 1'b0;
               dec_sel = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00; end
      1: begin dec_reg_we = 1'b1; dec_mem_we = 1'b0; dec_sel = 2'b01; end
      2: begin dec_reg_we = 1'b0; dec_mem_we = 1'b1; dec_sel = 2'b00; end
      default: begin dec_reg_we = rwe; dec_mem_we = 1'($urandom_range(0, 1));
                     dec_sel = 2'($urandom_range(0, 3)); end
    endcase
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      imem_data  = (c == wi) ? word : $urandom;
      imem_ready = (c == wi) ? 1'b1 : ((c > wi) ? 1'($urandom_range(0, 1)) : 1'b0);
      if (is_mem == 1)
        dmem_ready = (c == wi + 3 + wd) ? 1'b1 : ((c < wi + 3) ? 1'($urandom_range(0, 1)) : 1'b0);
      else
        dmem_ready = 1'($urandom_range(0, 1));
      #1;
      if (c <= wi)                                 exp_st = 0;
      else if (c == wi + 1)                        exp_st = 1;
      else if (c == wi + 2)                        exp_st = 2;
      else if (is_mem == 1 && c <= wi + 3 + wd)    exp_st = 3;
      else                                         exp_st = 4;
      if (state !== 3'(exp_st)) st_err++;
      if (imem_req) n_ireq++;
      if (dmem_req) n_dreq++;
      if (dmem_we)  n_dwe++;
      if (pc_we === 1'b1) begin
        got_pc = c; got_rwe = reg_we;
        break;
      end
    end
    n_checks++;
    if (got_pc !== exp_pc) $display("FAIL latency word=%h got=%0d exp=%0d", word, got_pc, exp_pc);
    else n_pass++;
    n_checks++;
    if (got_rwe !== ((cls == 0) ? rwe : (cls == 1))) $display("FAIL reg_we word=%h got=%b", word, got_rwe);
    else n_pass++;
    n_checks++;
    if (st_err !== 0) $display("FAIL state_trace word=%h bad_cycles=%0d exp=0", word, st_err);
    else n_pass++;
    n_checks++;
    if (n_ireq !== wi + 1) $display("FAIL imem_req_cycles word=%h got=%0d exp=%0d", word, n_ireq, wi + 1);
    else n_pass++;
    n_checks++;
    if (n_dreq !== (is_mem ? wd + 1 : 0)) $display("FAIL dmem_req_cycles word=%h got=%0d exp=%0d", word, n_dreq, is_mem ? wd + 1 : 0);
    else n_pass++;
    n_checks++;
    if (n_dwe !== ((cls == 2) ? wd + 1 : 0)) $display("FAIL dmem_we_cycles word=%h got=%0d exp=%0d", word, n_dwe, (cls == 2) ? wd + 1 : 0);
    else n_pass++;
    @(posedge clk); #1;
    exp_instret = exp_instret + 32'd1;
    n_checks++;
    if (instret !== exp_instret) $display("FAIL instret word=%h got=%h exp=%h", word, instret, exp_instret);
    else n_pass++;
    n_checks++;
    if (instruction !== word) $display("FAIL instruction got=%h exp=%h", instruction, word);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
    imem_data = 32'hFFFF_FFFF; dec_reg_we = 1'b1; dec_mem_we = 1'b1; dec_sel = 2'b01;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    n_checks++;
    if ({imem_req, dmem_req, dmem_we, pc_we, reg_we} !== 5'b0)
      $display("FAIL reset_strobes got=%b exp=00000", {imem_req, dmem_req, dmem_we, pc_we, reg_we});
    else n_pass++;
    n_checks++;
    if (state !== 3'd0 || instruction !== 32'h13 || instret !== 32'd0 || trap !== 1'b0)
      $display("FAIL reset_values state=%0d instr=%h instret=%h trap=%b", state, instruction, instret, trap);
    else n_pass++;
    reset = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; exp_instret = 32'd0;
    #1;
    n_checks++;
    if (imem_req !== 1'b1) $display("FAIL first_imem_req got=%b exp=1", imem_req);
    else n_pass++;
  endtask

  task automatic test_directed();
    run_instr(32'h0050_0093, 0, 0, 0, 1'b1);  // addi, zero wait
    run_instr(32'h0000_A103, 1, 0, 2, 1'b1);  // lw, data ready after 2 waits
    run_instr(32'h0020_A023, 2, 0, 0, 1'b0);  // sw, zero wait
    run_instr(32'h0000_0463, 0, 2, 0, 1'b0);  // beq, fetch waits
  endtask

  task automatic test_stall();
    int err;
    dec_reg_we = 1'b1; dec_mem_we = 1'b0; dec_sel = 2'b00;
    @(negedge clk);
    stall = 1'b1; imem_ready = 1'b1; imem_data = 32'h0010_0113;
    #1;
    n_checks++;
    if (imem_req !== 1'b0) $display("FAIL stall_imem_req got=%b exp=0", imem_req);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (state !== 3'd0 || instruction !== 32'h0000_0463)
      $display("FAIL stall_hold state=%0d instr=%h exp_state=0 exp_instr=00000463", state, instruction);
    else n_pass++;
    @(negedge clk);
    stall = 1'b0; imem_ready = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b1) $display("FAIL stall_release_req got=%b exp=1", imem_req);
    else n_pass++;
    @(negedge clk);
    imem_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (instruction !== 32'h0010_0113 || state !== 3'd1)
      $display("FAIL stall_latch instr=%h state=%0d exp=00100113/1", instruction, state);
    else n_pass++;
    @(negedge clk); imem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk); stall = 1'b1;
    #1;
    err = (pc_we !== 1'b0 || reg_we !== 1'b0) ? 1 : 0;
    @(posedge clk); #1;
    n_checks++;
    if (err != 0 || state !== 3'd4 || instret !== exp_instret)
      $display("FAIL stall_wb err=%0d state=%0d instret=%h exp=%h", err, state, instret, exp_instret);
    else n_pass++;
    @(negedge clk); stall = 1'b0;
    #1;
    n_checks++;
    if (pc_we !== 1'b1 || reg_we !== 1'b1) $display("FAIL stall_wb_release pc_we=%b reg_we=%b exp=1/1", pc_we, reg_we);
    else n_pass++;
    @(posedge clk); #1;
    exp_instret = exp_instret + 32'd1;
    n_checks++;
    if (instret !== exp_instret || state !== 3'd0)
      $display("FAIL stall_retire instret=%h exp=%h state=%0d", instret, exp_instret, state);
    else n_pass++;
  endtask

  task automatic test_illegal();
`ifdef SEQ_TRAP_EN
    int err;
    err = 0;
    dec_reg_we = 1'b1; dec_mem_we = 1'b0; dec_sel = 2'b00;
    @(negedge clk); imem_ready = 1'b1; imem_data = 32'hFFFF_FFFF;
    for (int c = 1; c < 8; c++) begin
      @(negedge clk); imem_ready = 1'b1; dmem_ready = 1'b1;
      #1;
      if (pc_we !== 1'b0 || reg_we !== 1'b0 || dmem_req !== 1'b0 || imem_req !== 1'b0) err++;
      if (c >= 2 && (state !== 3'd5 || trap !== 1'b1)) err++;
    end
    n_checks++;
    if (err != 0 || instret !== exp_instret)
      $display("FAIL trap_halt errs=%0d instret=%h exp=%h", err, instret, exp_instret);
    else n_pass++;
    imem_ready = 1'b0; dmem_ready = 1'b0; reset = 1'b1;
    @(posedge clk);
    @(negedge clk); reset = 1'b0; exp_instret = 32'd0;
    #1;
    n_checks++;
    if (trap !== 1'b0 || state !== 3'd0) $display("FAIL trap_cleared trap=%b state=%0d", trap, state);
    else n_pass++;
`else
    run_instr(32'hFFFF_FFFF, 3, 0, 0, 1'b1);
    run_instr(32'h0050_0092, 3, 1, 0, 1'b1);
    n_checks++;
    if (trap !== 1'b0) $display("FAIL trap_tied got=%b exp=0", trap);
    else n_pass++;
`endif
  endtask

  task automatic test_wrap();
    force dut.instret = 32'hFFFF_FFFF;
    #1;
    release dut.instret;
    exp_instret = 32'hFFFF_FFFF;
    run_instr(32'h0050_0093, 0, 0, 0, 1'b1);
    n_checks++;
    if (instret !== 32'd0) $display("FAIL instret_wrap got=%h exp=00000000", instret);
    else n_pass++;
  endtask

  task automatic test_reset_mid_mem();
    dec_reg_we = 1'b1; dec_mem_we = 1'b0; dec_sel = 2'b01;
    @(negedge clk); imem_ready = 1'b1; imem_data = 32'h0000_A103; dmem_ready = 1'b0;
    @(negedge clk); imem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    n_checks++;
    if (dmem_req !== 1'b1 || state !== 3'd3) $display("FAIL mid_mem_req dmem_req=%b state=%0d exp=1/3", dmem_req, state);
    else n_pass++;
    @(negedge clk); reset = 1'b1;
    #1;
    n_checks++;
    if ({imem_req, dmem_req, dmem_we, pc_we, reg_we} !== 5'b0)
      $display("FAIL mid_mem_reset_strobes got=%b exp=00000", {imem_req, dmem_req, dmem_we, pc_we, reg_we});
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (state !== 3'd0 || instret !== 32'd0 || instruction !== 32'h13)
      $display("FAIL mid_mem_reset_state state=%0d instret=%h instr=%h", state, instret, instruction);
    else n_pass++;
    @(negedge clk); reset = 1'b0; exp_instret = 32'd0;
  endtask

  task automatic test_random();
    logic [31:0] alu_t [6];
    logic [31:0] ld_t [2];
    logic [31:0] st_t [2];
    logic [31:0] il_t [4];
    int cls;
    logic [31:0] w;
    alu_t = '{32'h0050_0093, 32'h0020_81B3, 32'h0000_0463, 32'h1234_52B7, 32'h0080_00EF, 32'h0000_0517};
    ld_t  = '{32'h0000_A103, 32'h0041_2283};
    st_t  = '{32'h0020_A023, 32'h0051_2223};
    il_t  = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_007F, 32'h0000_000B};
    for (int i = 0; i < 24; i++) begin
`ifdef SEQ_TRAP_EN
      cls = $urandom_range(0, 2);
`else
      cls = $urandom_range(0, 3);
`endif
      case (cls)
        0:       w = alu_t[$urandom_range(0, 5)];
        1:       w = ld_t[$urandom_range(0, 1)];
        2:       w = st_t[$urandom_range(0, 1)];
        default: w = il_t[$urandom_range(0, 3)];
      endcase
      run_instr(w, cls, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_invariants();
    n_checks++;
    if (inv_err !== 0) $display("FAIL reg_we_outside_wb got=%0d exp=0", inv_err);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_illegal();
    test_wrap();
    test_reset_mid_mem();
    test_random();
    test_invariants();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
